branch_exec: RTL and testbench
==============================

Name: branch_exec

Overview:
- Sequential execute stage that consumes the take-branch decision for short conditional jumps, JMPS, LOOP/LOOPZ/LOOPNZ and JCXZ.
- Computes the branch target and decrements ECX/CX for the LOOP family.
- Performs the CS limit check, then either redirects instruction fetch through a request/acknowledge handshake or raises #GP.
- Sits between decode/operand latch and the fetch/prefetch unit; the condition input comes from the branch-condition evaluator, which is driven from the same ir/ecx/flags values.

Parameters:
- ADDR_W, 32, width of EIP, ECX and CS limit.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous active-high reset.
- start_i  input  1  branch op valid; accepted when start_i & ready_o.
- ready_o  output  1  high only in IDLE.
- ir_i  input  8  opcode (70-7F, E0-E3, EB).
- disp_i  input  32  displacement, already sign-extended by the decoder.
- next_eip_i  input  32  EIP of the following instruction.
- ecx_i  input  32  current ECX.
- db_i  input  1  CS descriptor D/B bit; 1 = 32-bit, 0 = 16-bit.
- cs_limit_i  input  32  effective CS limit.
- take_br_i  input  1  branch condition from the evaluator for the same ir/ecx/flags.
- abort_i  input  1  synchronous pipeline flush.
- redirect_o  output  1  fetch redirect request.
- redirect_eip_o  output  32  target EIP.
- redirect_ack_i  input  1  fetch accepted the redirect.
- ecx_we_o  output  1  ECX write strobe, 1-cycle pulse.
- ecx_o  output  32  new ECX value.
- gp_fault_o  output  1  #GP(0) request, 1-cycle pulse.
- done_o  output  1  op retired, 1-cycle pulse.
- taken_o  output  1  valid with done_o; 1 = branch taken.

Behaviour:
- Reset (async, rst_i high): state=IDLE, ready_o=1; redirect_o, ecx_we_o, gp_fault_o, done_o, taken_o = 0; redirect_eip_o and ecx_o = 0.
- States: IDLE, CALC, CHECK, REDIRECT, DONE, FAULT.
- IDLE:
  - On start_i, latch all inputs including take_br_i; go to CALC.
  - ready_o drops in the next cycle.
- CALC, one cycle:
  - tgt = next_eip + disp, modulo 2^32. If db=0, tgt[31:16] is forced to 0.
  - is_loop = ir in {E0, E1, E2}.
  - For is_loop: if db=1, necx = ecx - 1 (32-bit wrap); if db=0, necx = {ecx[31:16], ecx[15:0] - 1} (16-bit wrap, upper half preserved).
  - All other opcodes, including E3 (JCXZ): no ECX change.
- CHECK, one cycle:
  - If latched take=0: go to DONE with taken=0.
  - If take=1 and tgt > cs_limit (unsigned): go to FAULT.
  - Otherwise go to REDIRECT.
- REDIRECT:
  - redirect_o=1 and redirect_eip_o=tgt, both held stable until redirect_ack_i is sampled high.
  - Then go to DONE with taken=1. Ack may arrive in the first REDIRECT cycle, giving minimum latency.
- DONE, one cycle:
  - done_o=1, taken_o set.
  - If is_loop: ecx_we_o=1 with ecx_o=necx. The write happens whether or not the branch is taken.
  - Next state IDLE.
- FAULT, one cycle:
  - gp_fault_o=1, done_o=0, no ECX write (instruction restartable), no redirect.
  - Next state IDLE.
- Latency from accept to done_o:
  - Not taken: 3 cycles.
  - Taken: 3 + ack wait (minimum 4).
- abort_i: in any non-IDLE state, go to IDLE next cycle. Drop redirect_o and suppress ecx_we_o, done_o and gp_fault_o. abort_i has priority over a simultaneous redirect_ack_i. Ignored in IDLE.
- start_i outside IDLE is ignored.
- Unknown opcode: treated as not taken (the evaluator supplies 0); no ECX write.
- take_br_i is not recomputed. The evaluator's LOOP condition (CX before decrement != 1) matches "decremented CX != 0" by definition.

Test Plan:
- JE (74), take=1, next_eip=0x1000, disp=0xFFFFFFF0, db=1, limit=0xFFFFFFFF -> redirect_eip_o=0x00000FF0; ack after 2 cycles -> done_o, taken_o=1, no ecx_we_o.
- LOOP (E2), db=0, ecx=0xABCD0001, take=0 -> done_o 3 cycles after accept, taken_o=0, ecx_we_o with ecx_o=0xABCD0000.
- LOOP (E2), db=0, ecx=0x12340000, take=1, next_eip=0xFFF0, disp=0x20 -> redirect_eip_o=0x00000010 (16-bit wrap); ecx_o=0x1234FFFF.
- JMPS (EB), take=1, tgt=0x2000, limit=0x1FFF -> gp_fault_o pulse, no redirect_o, no done_o; same with limit=0x2000 -> redirect issued.
- LOOPNZ with abort_i asserted in REDIRECT together with redirect_ack_i -> IDLE next cycle, no ecx_we_o, no done_o, ready_o=1.
- rst_i asserted mid-REDIRECT -> all outputs 0 immediately (async), ready_o=1.

Source files
------------

// File: rtl/branch_exec_if.sv
// Interface bundling the branch_exec operand, fetch-redirect and retirement signals.
// The master side drives the op and the fetch acknowledge; the slave is the execute stage.
interface branch_exec_if #(
    parameter int ADDR_W = 32
);
    logic              start_i;
    logic              ready_o;
    logic [7:0]        ir_i;
    logic [ADDR_W-1:0] disp_i;
    logic [ADDR_W-1:0] next_eip_i;
    logic [ADDR_W-1:0] ecx_i;
    logic              db_i;
    logic [ADDR_W-1:0] cs_limit_i;
    logic              take_br_i;
    logic              abort_i;
    logic              redirect_o;
    logic [ADDR_W-1:0] redirect_eip_o;
    logic              redirect_ack_i;
    logic              ecx_we_o;
    logic [ADDR_W-1:0] ecx_o;
    logic              gp_fault_o;
    logic              done_o;
    logic              taken_o;

    modport master (
        output start_i, ir_i, disp_i, next_eip_i, ecx_i, db_i, cs_limit_i,
               take_br_i, abort_i, redirect_ack_i,
        input  ready_o, redirect_o, redirect_eip_o, ecx_we_o, ecx_o,
               gp_fault_o, done_o, taken_o
    );

    modport slave (
        input  start_i, ir_i, disp_i, next_eip_i, ecx_i, db_i, cs_limit_i,
               take_br_i, abort_i, redirect_ack_i,
        output ready_o, redirect_o, redirect_eip_o, ecx_we_o, ecx_o,
               gp_fault_o, done_o, taken_o
    );
endinterface

// File: rtl/branch_exec.sv
// Execute stage for short Jcc/JMPS/LOOPxx/JCXZ: target calc, CX/ECX decrement,
// CS limit check, then either a fetch redirect handshake or a #GP request.
module branch_exec #(
    parameter int ADDR_W = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    branch_exec_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, CALC, CHECK, REDIRECT, DONE, FAULT} state_t;

    state_t            state_q;
    logic              ready_q, redirect_q, ecx_we_q, gp_q, done_q, taken_q;
    logic [ADDR_W-1:0] redirect_eip_q, ecx_out_q;

    logic [7:0]        ir_q;
    logic [ADDR_W-1:0] disp_q, next_eip_q, ecx_q, limit_q, tgt_q, necx_q;
    logic              db_q, take_q;

    logic [ADDR_W-1:0] tgt_d, necx_d;
    logic              is_loop;
    logic              accept;

    // In 16-bit code segments EIP wraps at 64K.
    function automatic logic [ADDR_W-1:0] calc_target(input logic [ADDR_W-1:0] eip,
                                                      input logic [ADDR_W-1:0] disp,
                                                      input logic db);
        logic [ADDR_W-1:0] sum;
        sum = eip + disp;
        if (!db) sum[ADDR_W-1:16] = '0;
        return sum;
    endfunction

    // CX-only decrement leaves the upper half of ECX untouched.
    function automatic logic [ADDR_W-1:0] dec_count(input logic [ADDR_W-1:0] cnt,
                                                    input logic db);
        logic [ADDR_W-1:0] res;
        if (db) res = cnt - ADDR_W'(1);
        else    res = {cnt[ADDR_W-1:16], cnt[15:0] - 16'd1};
        return res;
    endfunction

    always_comb begin
        accept  = (state_q == IDLE) && bus.start_i;
        is_loop = (ir_q == 8'hE0) || (ir_q == 8'hE1) || (ir_q == 8'hE2);
        tgt_d   = calc_target(next_eip_q, disp_q, db_q);
        necx_d  = is_loop ? dec_count(ecx_q, db_q) : ecx_q;
    end

    // Operand latch (IDLE) and computed results (CALC)
    always_ff @(posedge clk_i) begin
        if (accept) begin
            ir_q       <= bus.ir_i;
            disp_q     <= bus.disp_i;
            next_eip_q <= bus.next_eip_i;
            ecx_q      <= bus.ecx_i;
            db_q       <= bus.db_i;
            limit_q    <= bus.cs_limit_i;
            take_q     <= bus.take_br_i;
        end
        if (state_q == CALC) begin
            tgt_q  <= tgt_d;
            necx_q <= necx_d;
        end
    end

    // Control FSM; abort wins over everything, including a same-cycle redirect ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            ready_q        <= 1'b1;
            redirect_q     <= 1'b0;
            ecx_we_q       <= 1'b0;
            gp_q           <= 1'b0;
            done_q         <= 1'b0;
            taken_q        <= 1'b0;
            redirect_eip_q <= '0;
            ecx_out_q      <= '0;
        end else begin
            done_q   <= 1'b0;
            gp_q     <= 1'b0;
            ecx_we_q <= 1'b0;
            if (state_q != IDLE && bus.abort_i) begin
                state_q    <= IDLE;
                ready_q    <= 1'b1;
                redirect_q <= 1'b0;
                taken_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start_i) begin
                            state_q <= CALC;
                            ready_q <= 1'b0;
                        end
                    end
                    CALC: state_q <= CHECK;
                    CHECK: begin
                        if (!take_q) begin
                            state_q  <= DONE;
                            done_q   <= 1'b1;
                            taken_q  <= 1'b0;
                            ecx_we_q <= is_loop;
                            if (is_loop) ecx_out_q <= necx_q;
                        end else if (tgt_q > limit_q) begin
                            state_q <= FAULT;
                            gp_q    <= 1'b1;
                        end else begin
                            state_q        <= REDIRECT;
                            redirect_q     <= 1'b1;
                            redirect_eip_q <= tgt_q;
                        end
                    end
                    REDIRECT: begin
                        if (bus.redirect_ack_i) begin
                            state_q    <= DONE;
                            redirect_q <= 1'b0;
                            done_q     <= 1'b1;
                            taken_q    <= 1'b1;
                            ecx_we_q   <= is_loop;
                            if (is_loop) ecx_out_q <= necx_q;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        taken_q <= 1'b0;
                    end
                    FAULT: begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                    default: begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.ready_o        = ready_q;
    assign bus.redirect_o     = redirect_q;
    assign bus.redirect_eip_o = redirect_eip_q;
    assign bus.ecx_we_o       = ecx_we_q;
    assign bus.ecx_o          = ecx_out_q;
    assign bus.gp_fault_o     = gp_q;
    assign bus.done_o         = done_q;
    assign bus.taken_o        = taken_q;

endmodule

// File: tb/tb_branch_exec.sv
// Scoreboard bench for branch_exec: expectations are queued per op when it is driven
// and compared against what the DUT retires.
module tb_branch_exec;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    branch_exec_if #(.ADDR_W(32)) bif();

    branch_exec #(.ADDR_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bif.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          n_done;
        logic        taken;
        int          n_gp;
        int          n_we;
        logic [31:0] ecx;
        logic        redir;
        logic [31:0] reip;
        int          done_cyc;
        int          ready_cyc;
    } exp_t;

    exp_t sb_q[$];

    task automatic run_op(input string name, input logic [7:0] ir, input logic [31:0] disp,
                          input logic [31:0] neip, input logic [31:0] ecx, input logic db,
                          input logic [31:0] lim, input logic take, input int ack_wait,
                          input bit do_abort, input bit hold_start);
        exp_t e, got;
        logic [31:0] sum, tgt, necx;
        bit loopop, fin, stable, redir_at_ready;
        int cyc;

        // Reference model
        sum    = neip + disp;
        tgt    = db ? sum : {16'h0000, sum[15:0]};
        loopop = (ir == 8'hE0) || (ir == 8'hE1) || (ir == 8'hE2);
        necx   = ecx;
        if (loopop) necx = db ? ecx - 32'd1 : {ecx[31:16], ecx[15:0] - 16'd1};
        e = '{n_done: 0, taken: 1'b0, n_gp: 0, n_we: 0, ecx: necx, redir: 1'b0,
              reip: tgt, done_cyc: -1, ready_cyc: 4};
        if (do_abort) begin
            e.redir = 1'b1;
        end else if (!take) begin
            e.n_done = 1; e.done_cyc = 3; e.n_we = loopop ? 1 : 0;
        end else if (tgt > lim) begin
            e.n_gp = 1;
        end else begin
            e.n_done = 1; e.taken = 1'b1; e.redir = 1'b1; e.n_we = loopop ? 1 : 0;
            e.done_cyc = 4 + ack_wait; e.ready_cyc = 5 + ack_wait;
        end
        sb_q.push_back(e);

        @(negedge clk);
        bif.ir_i = ir; bif.disp_i = disp; bif.next_eip_i = neip; bif.ecx_i = ecx;
        bif.db_i = db; bif.cs_limit_i = lim; bif.take_br_i = take; bif.start_i = 1'b1;
        @(posedge clk);

        got = '{n_done: 0, taken: 1'b0, n_gp: 0, n_we: 0, ecx: 32'h0, redir: 1'b0,
                reip: 32'h0, done_cyc: -1, ready_cyc: -1};
        fin = 1'b0; stable = 1'b1; redir_at_ready = 1'b0; cyc = 0;
        for (int k = 0; k < 40 && !fin; k++) begin
            int n_rc;
            @(negedge clk);
            cyc++;
            if (bif.done_o) begin
                got.n_done++; got.done_cyc = cyc; got.taken = bif.taken_o;
            end
            if (bif.gp_fault_o) got.n_gp++;
            if (bif.ecx_we_o) begin
                got.n_we++; got.ecx = bif.ecx_o;
            end
            if (bif.redirect_o) begin
                if (!got.redir) got.reip = bif.redirect_eip_o;
                else if (bif.redirect_eip_o !== got.reip) stable = 1'b0;
                got.redir = 1'b1;
            end
            if (bif.ready_o && cyc > 1) begin
                fin = 1'b1; got.ready_cyc = cyc; redir_at_ready = bif.redirect_o;
            end
            if (!hold_start || fin) bif.start_i = 1'b0;
            if (hold_start && !fin) begin
                bif.disp_i = $urandom(); bif.next_eip_i = $urandom();
                bif.ecx_i = $urandom(); bif.take_br_i = ~take; bif.ir_i = 8'hEB;
            end
            bif.redirect_ack_i = 1'b0;
            bif.abort_i        = 1'b0;
            n_rc = 0;
            if (bif.redirect_o && !fin) begin
                // cycles spent in REDIRECT so far, counting this one
                n_rc = cyc - 2;
                if (do_abort && n_rc == 1) begin
                    bif.redirect_ack_i = 1'b1; bif.abort_i = 1'b1;
                end else if (!do_abort && n_rc == ack_wait + 1) begin
                    bif.redirect_ack_i = 1'b1;
                end
            end
        end
        bif.start_i = 1'b0; bif.redirect_ack_i = 1'b0; bif.abort_i = 1'b0;
        if (!fin) chk({name, ".timeout"}, 32'd0, 32'd1);

        e = sb_q.pop_front();
        chk({name, ".done_cnt"}, got.n_done, e.n_done);
        if (e.n_done == 1) begin
            chk({name, ".taken"}, {31'd0, got.taken}, {31'd0, e.taken});
            chk({name, ".done_cyc"}, got.done_cyc, e.done_cyc);
        end
        chk({name, ".gp_cnt"}, got.n_gp, e.n_gp);
        chk({name, ".ecx_we_cnt"}, got.n_we, e.n_we);
        if (e.n_we == 1) chk({name, ".ecx_o"}, got.ecx, e.ecx);
        chk({name, ".redirect"}, {31'd0, got.redir}, {31'd0, e.redir});
        if (e.redir) begin
            chk({name, ".redirect_eip"}, got.reip, e.reip);
            chk({name, ".eip_stable"}, {31'd0, stable}, 32'd1);
        end
        chk({name, ".ready_cyc"}, got.ready_cyc, e.ready_cyc);
        chk({name, ".redir_idle"}, {31'd0, redir_at_ready}, 32'd0);
    endtask

    task automatic reset_mid_redirect();
        bit seen;
        @(negedge clk);
        bif.ir_i = 8'h74; bif.disp_i = 32'h0000_0100; bif.next_eip_i = 32'h0000_2000;
        bif.ecx_i = 32'h5; bif.db_i = 1'b1; bif.cs_limit_i = 32'hFFFF_FFFF;
        bif.take_br_i = 1'b1; bif.start_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bif.start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (bif.redirect_o) seen = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid.redirect_seen", {31'd0, seen}, 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_mid.ready", {31'd0, bif.ready_o}, 32'd1);
        chk("rst_mid.redirect", {31'd0, bif.redirect_o}, 32'd0);
        chk("rst_mid.redirect_eip", bif.redirect_eip_o, 32'd0);
        chk("rst_mid.outs", {28'd0, bif.done_o, bif.taken_o, bif.gp_fault_o, bif.ecx_we_o}, 32'd0);
        chk("rst_mid.ecx_o", bif.ecx_o, 32'd0);
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_mid.ready_after", {31'd0, bif.ready_o}, 32'd1);
    endtask

    initial begin
        rst_i = 1'b1;
        bif.start_i = 1'b0; bif.ir_i = 8'h00; bif.disp_i = 32'h0; bif.next_eip_i = 32'h0;
        bif.ecx_i = 32'h0; bif.db_i = 1'b0; bif.cs_limit_i = 32'h0; bif.take_br_i = 1'b0;
        bif.abort_i = 1'b0; bif.redirect_ack_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.ready", {31'd0, bif.ready_o}, 32'd1);
        chk("reset.outs", {27'd0, bif.redirect_o, bif.done_o, bif.taken_o, bif.gp_fault_o,
                           bif.ecx_we_o}, 32'd0);
        chk("reset.redirect_eip", bif.redirect_eip_o, 32'd0);
        chk("reset.ecx_o", bif.ecx_o, 32'd0);
        rst_i = 1'b0;
        @(negedge clk);

        //      name      ir     disp          neip          ecx           db    limit         take ack ab hold
        run_op("je",      8'h74, 32'hFFFF_FFF0, 32'h0000_1000, 32'h0000_0007, 1'b1, 32'hFFFF_FFFF, 1'b1, 2, 0, 0);
        run_op("loop_nt", 8'hE2, 32'h0000_0010, 32'h0000_0100, 32'hABCD_0001, 1'b0, 32'h0000_FFFF, 1'b0, 0, 0, 0);
        run_op("loop_w16",8'hE2, 32'h0000_0020, 32'h0000_FFF0, 32'h1234_0000, 1'b0, 32'h0000_FFFF, 1'b1, 0, 0, 0);
        run_op("jmps_gp", 8'hEB, 32'h0000_0100, 32'h0000_1F00, 32'h0000_0000, 1'b1, 32'h0000_1FFF, 1'b1, 0, 0, 0);
        run_op("jmps_lim",8'hEB, 32'h0000_0100, 32'h0000_1F00, 32'h0000_0000, 1'b1, 32'h0000_2000, 1'b1, 1, 0, 0);
        run_op("loopnz_ab",8'hE0,32'h0000_0040, 32'h0000_3000, 32'h0000_0009, 1'b1, 32'hFFFF_FFFF, 1'b1, 0, 1, 0);
        run_op("jcxz",    8'hE3, 32'h0000_0010, 32'h0000_4000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 0, 0, 0);
        run_op("loop32",  8'hE2, 32'hFFFF_FF00, 32'h0001_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 3, 0, 1);
        run_op("unknown", 8'h90, 32'h0000_0004, 32'h0000_5000, 32'h0000_0003, 1'b1, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
        run_op("loopz_gp",8'hE1, 32'h0000_0010, 32'h0000_8000, 32'h0000_0002, 1'b1, 32'h0000_8000, 1'b1, 0, 0, 0);
        run_op("jne_nt",  8'h75, 32'h0000_0010, 32'h0000_6000, 32'h0000_0001, 1'b0, 32'h0000_FFFF, 1'b0, 0, 0, 0);
        reset_mid_redirect();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
